// File: rtl/spi_slave_fifo.sv
// SPI slave with runtime mode/bit-order selection, multi-word bursts and
// TX/RX FIFOs; sclk, cs_n and mosi are oversampled in the clk domain.

module spi_slave_fifo_buf #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_wr,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_rd,
  output logic [W-1:0]           o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(D+1)-1:0] o_level
);
  localparam int AW = $clog2(D);
  localparam int LW = $clog2(D+1);

  logic [W-1:0]  r_mem [D];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_do_wr;
  logic          w_do_rd;

  assign o_full  = (r_level == LW'(D));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_do_wr = i_wr & ~o_full;
  assign w_do_rd = i_rd & ~o_empty;

  // NOTE: the storage is reset too, so the show-ahead head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_wr) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_wr & ~w_do_rd)      r_level <= r_level + LW'(1);
      else if (w_do_rd & ~w_do_wr) r_level <= r_level - LW'(1);
    end
  end
endmodule

module spi_slave_fifo #(
  parameter int              WIDTH       = 8,
  parameter int              DEPTH       = 4,
  parameter int              SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] FILL       = {WIDTH{1'b1}}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       cs_n,
  input  logic                       mosi,
  output logic                       miso,
  output logic                       miso_oe,
  input  logic [1:0]                 cfg_mode,
  input  logic                       cfg_lsb_first,
  input  logic                       tx_wr,
  input  logic [WIDTH-1:0]           tx_wdata,
  output logic                       tx_full,
  output logic [$clog2(DEPTH+1)-1:0] tx_level,
  input  logic                       rx_rd,
  output logic [WIDTH-1:0]           rx_rdata,
  output logic                       rx_empty,
  output logic [$clog2(DEPTH+1)-1:0] rx_level,
  output logic                       rx_word_done,
  output logic                       frame_active,
  output logic                       err_underrun,
  output logic                       err_overrun,
  output logic                       err_partial,
  input  logic                       clr_err
);
  localparam int CW = $clog2(WIDTH);

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_n_sync, r_mosi_sync;
  logic                   r_sclk_d, r_cs_n_d;
  logic                   r_active, r_cpol, r_cpha, r_lsb, r_load_pend;
  logic [CW-1:0]          r_bit_cnt;
  logic [WIDTH-1:0]       r_tx_sh, r_rx_sh;
  logic                   r_miso, r_word_done;
  logic                   r_err_underrun, r_err_overrun, r_err_partial;

  logic w_sclk, w_cs_n, w_mosi;
  logic w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;
  logic w_lead, w_trail, w_in_frame, w_capture, w_shift;
  logic w_load, w_load_lsb, w_tx_pop, w_tx_empty, w_rx_full, w_word_end;
  logic [WIDTH-1:0] w_tx_head, w_load_word, w_rx_word;

  // NOTE: non-blocking so each stage takes the previous stage's old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_cs_n_sync <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_n_d    <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_n_sync <= {r_cs_n_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_n_d    <= r_cs_n_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_n      = r_cs_n_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_fall   = r_cs_n_d & ~w_cs_n;
  assign w_cs_rise   = ~r_cs_n_d & w_cs_n;
  assign w_sclk_rise = ~r_sclk_d & w_sclk;
  assign w_sclk_fall = r_sclk_d & ~w_sclk;

  // Frame end takes priority over an sclk edge seen in the same cycle.
  assign w_lead     = r_cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail    = r_cpol ? w_sclk_rise : w_sclk_fall;
  assign w_in_frame = r_active & ~w_cs_rise;
  assign w_capture  = w_in_frame & (r_cpha ? w_trail : w_lead);
  assign w_shift    = w_in_frame & (r_cpha ? w_lead : w_trail);
  assign w_word_end = w_capture & (r_bit_cnt == CW'(WIDTH-1));

  // CPHA=0 loads at frame start and after each full word; CPHA=1 at bit 0.
  assign w_load      = (w_cs_fall & ~cfg_mode[0]) |
                       (w_shift & (r_cpha ? (r_bit_cnt == '0) : r_load_pend));
  assign w_load_lsb  = w_cs_fall ? cfg_lsb_first : r_lsb;
  assign w_load_word = w_tx_empty ? FILL : w_tx_head;
  assign w_tx_pop    = w_load & ~w_tx_empty;
  assign w_rx_word   = r_lsb ? {w_mosi, r_rx_sh[WIDTH-1:1]}
                             : {r_rx_sh[WIDTH-2:0], w_mosi};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active       <= 1'b0;
      r_cpol         <= 1'b0;
      r_cpha         <= 1'b0;
      r_lsb          <= 1'b0;
      r_load_pend    <= 1'b0;
      r_bit_cnt      <= '0;
      r_tx_sh        <= '0;
      r_rx_sh        <= '0;
      r_miso         <= 1'b0;
      r_word_done    <= 1'b0;
      r_err_underrun <= 1'b0;
      r_err_overrun  <= 1'b0;
      r_err_partial  <= 1'b0;
    end else begin
      r_word_done    <= w_word_end;
      r_err_underrun <= (w_load & w_tx_empty) | (r_err_underrun & ~clr_err);
      r_err_overrun  <= (w_word_end & w_rx_full) | (r_err_overrun & ~clr_err);
      r_err_partial  <= (w_cs_rise & (r_bit_cnt != '0)) | (r_err_partial & ~clr_err);

      if (w_load) begin
        r_tx_sh <= w_load_word;
        r_miso  <= w_load_lsb ? w_load_word[0] : w_load_word[WIDTH-1];
      end else if (w_shift) begin
        if (r_lsb) begin
          r_tx_sh <= {1'b0, r_tx_sh[WIDTH-1:1]};
          r_miso  <= r_tx_sh[1];
        end else begin
          r_tx_sh <= {r_tx_sh[WIDTH-2:0], 1'b0};
          r_miso  <= r_tx_sh[WIDTH-2];
        end
      end

      if (w_capture) begin
        r_rx_sh   <= w_rx_word;
        r_bit_cnt <= w_word_end ? '0 : r_bit_cnt + CW'(1);
      end

      // Later assignments here override the datapath updates above.
      if (w_cs_fall) begin
        r_active    <= 1'b1;
        r_cpol      <= cfg_mode[1];
        r_cpha      <= cfg_mode[0];
        r_lsb       <= cfg_lsb_first;
        r_bit_cnt   <= '0;
        r_load_pend <= 1'b0;
      end else if (w_cs_rise) begin
        r_active    <= 1'b0;
        r_miso      <= 1'b0;
        r_bit_cnt   <= '0;
        r_rx_sh     <= '0;
        r_load_pend <= 1'b0;
      end else if (w_word_end & ~r_cpha) begin
        r_load_pend <= 1'b1;
      end else if (w_load) begin
        r_load_pend <= 1'b0;
      end
    end
  end

  spi_slave_fifo_buf #(.W(WIDTH), .D(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (tx_wr),
    .i_wdata (tx_wdata),
    .i_rd    (w_tx_pop),
    .o_rdata (w_tx_head),
    .o_full  (tx_full),
    .o_empty (w_tx_empty),
    .o_level (tx_level)
  );

  spi_slave_fifo_buf #(.W(WIDTH), .D(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (w_word_end),
    .i_wdata (w_rx_word),
    .i_rd    (rx_rd),
    .o_rdata (rx_rdata),
    .o_full  (w_rx_full),
    .o_empty (rx_empty),
    .o_level (rx_level)
  );

  assign miso         = r_miso;
  assign miso_oe      = r_active;
  assign frame_active = r_active;
  assign rx_word_done = r_word_done;
  assign err_underrun = r_err_underrun;
  assign err_overrun  = r_err_overrun;
  assign err_partial  = r_err_partial;
endmodule
